// File: rtl/freq_bcd_converter_if.sv
// Count-in / BCD-out bundle between the edge counter, the BCD converter and the display driver.
interface freq_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    cnt_in;
  logic                cnt_valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic                busy;
  logic                overrun;

  modport master (output cnt_in, cnt_valid,
                  input  bcd_out, bcd_valid, busy, overrun);
  modport slave  (input  cnt_in, cnt_valid,
                  output bcd_out, bcd_valid, busy, overrun);
endinterface

// File: rtl/freq_bcd_converter.sv
// Sequential binary-to-BCD (double dabble) converter with a one-deep pending buffer.
// Optional macro FREQ_BCD_BLANK_EN replaces leading zero digits with 4'hF.
module freq_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  freq_bcd_converter_if.slave   bus
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ovr_q, ovr_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             bval_q, bval_d;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_fmt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      bcd_q      <= '0;
      bval_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovr_q      <= ovr_d;
      bcd_q      <= bcd_d;
      bval_q     <= bval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cnt_valid || pend_vld_q) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1))             state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5 before the shift keeps each digit <= 9 afterwards.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      logic [3:0] nib;
      nib = sr_q[WIDTH+4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  always_comb begin
    bcd_fmt = sr_q[SW-1 -: BW];
`ifdef FREQ_BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS-1; i >= 1; i--) begin
        if (lead && bcd_fmt[4*i +: 4] == 4'd0) bcd_fmt[4*i +: 4] = 4'hF;
        else                                   lead = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_d      = ovr_q;
    bcd_d      = bcd_q;
    bval_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cnt_valid) begin
          // Fresh count beats a stale pending one; the dropped value is an overrun.
          sr_d  = {{BW{1'b0}}, bus.cnt_in};
          cnt_d = CW'(WIDTH);
          if (pend_vld_q) begin
            pend_vld_d = 1'b0;
            ovr_d      = 1'b1;
          end
        end else if (pend_vld_q) begin
          sr_d       = {{BW{1'b0}}, pend_q};
          cnt_d      = CW'(WIDTH);
          pend_vld_d = 1'b0;
        end
      end
      SHIFT: begin
        sr_d  = SW'({bcd_adj, sr_q[WIDTH-1:0]} << 1);
        cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
        bcd_d  = bcd_fmt;
        bval_d = 1'b1;
      end
      default: ;
    endcase

    if (state_q != IDLE && bus.cnt_valid) begin
      pend_d     = bus.cnt_in;
      pend_vld_d = 1'b1;
      if (pend_vld_q) ovr_d = 1'b1;
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = bval_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_freq_bcd_converter.sv
// Directed bench for freq_bcd_converter: latency, values, pending/overrun, mid-conversion reset.
module tb_freq_bcd_converter;
  localparam int W = 16;
  localparam int D = 5;

`ifdef FREQ_BCD_BLANK_EN
  localparam logic [19:0] E0 = 20'hFFFF0, E9 = 20'hFFFF9, E1234 = 20'hF1234, E305 = 20'hFF305;
  localparam logic [19:0] E100 = 20'hFF100, E200 = 20'hFF200, E300 = 20'hFF300, E7 = 20'hFFFF7;
`else
  localparam logic [19:0] E0 = 20'h00000, E9 = 20'h00009, E1234 = 20'h01234, E305 = 20'h00305;
  localparam logic [19:0] E100 = 20'h00100, E200 = 20'h00200, E300 = 20'h00300, E7 = 20'h00007;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  freq_bcd_converter_if #(.WIDTH(W), .DIGITS(D)) bus();
  freq_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [19:0] vq[$];
  int          tq[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.bcd_valid === 1'b1) begin
      vq.push_back(bus.bcd_out);
      tq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; value is sampled on the next rising edge.
  task automatic strobe(input logic [15:0] v);
    bus.cnt_in    = v;
    bus.cnt_valid = 1'b1;
    @(negedge clk);
    bus.cnt_valid = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input int n, input int budget);
    int k = 0;
    while (vq.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, vq.size(), n);
  endtask

  task automatic clr();
    vq.delete();
    tq.delete();
  endtask

  logic [15:0] vin [4] = '{16'd65535, 16'd1234, 16'd9, 16'd305};
  logic [19:0] vexp[4] = '{20'h65535, E1234, E9, E305};

  initial begin
    int lat, busyc;
    bit found;
    bus.cnt_in    = '0;
    bus.cnt_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_bcd_out", bus.bcd_out, 20'h0);
    chk("rst_bcd_valid", bus.bcd_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Zero input: valid in the 18th cycle after the strobe edge, busy for 17 cycles.
    clr();
    bus.cnt_in = '0; bus.cnt_valid = 1'b1;
    @(negedge clk);
    bus.cnt_valid = 1'b0;
    lat = 0; busyc = 0; found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      if (bus.busy) busyc++;
      if (bus.bcd_valid) begin found = 1'b1; lat = k; end
      else @(negedge clk);
    end
    chk("zero_latency", lat, 18);
    chk("zero_busy_cycles", busyc, 17);
    @(negedge clk); #1;
    chk("zero_valid_pulse_len", bus.bcd_valid, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("zero_pulses", vq.size(), 1);
    if (vq.size() >= 1) chk("zero_value", vq[0], E0);

    for (int i = 0; i < 4; i++) begin
      clr();
      strobe(vin[i]);
      wait_outs($sformatf("vec%0d_done", i), 1, 40);
      if (vq.size() >= 1) chk($sformatf("vec%0d_value", i), vq[0], vexp[i]);
      repeat (5) @(negedge clk);
      #1;
      chk($sformatf("vec%0d_pulses", i), vq.size(), 1);
    end

    // One value queued during busy: runs right after DONE, no overrun.
    clr();
    strobe(16'd100);
    repeat (4) @(negedge clk);
    strobe(16'd200);
    wait_outs("pend_done", 2, 80);
    if (vq.size() >= 2) begin
      chk("pend_first", vq[0], E100);
      chk("pend_second", vq[1], E200);
      chk("pend_gap", tq[1] - tq[0], 18);
    end
    chk("pend_overrun", bus.overrun, 1'b0);

    // Two values queued during busy: latest wins, overrun sticks until reset.
    clr();
    strobe(16'd100);
    repeat (2) @(negedge clk);
    strobe(16'd200);
    repeat (2) @(negedge clk);
    strobe(16'd300);
    wait_outs("ovr_done", 2, 80);
    if (vq.size() >= 2) begin
      chk("ovr_first", vq[0], E100);
      chk("ovr_second", vq[1], E300);
    end
    chk("ovr_flag", bus.overrun, 1'b1);
    repeat (40) @(negedge clk);
    #1;
    chk("ovr_no_extra", vq.size(), 2);
    chk("ovr_sticky", bus.overrun, 1'b1);
    rst = 1'b1; #1;
    chk("ovr_cleared_by_rst", bus.overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-conversion: abandoned, no valid, next conversion clean.
    clr();
    strobe(16'd4321);
    repeat (7) @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst_bcd_out", bus.bcd_out, 20'h0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_valid", bus.bcd_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("midrst_no_valid", vq.size(), 0);
    @(negedge clk);
    strobe(16'd7);
    wait_outs("after_rst_done", 1, 40);
    if (vq.size() >= 1) chk("after_rst_value", vq[0], E7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
